eq_sequencer: RTL
=================

// Module: eq_sequencer
// PURPOSE
//  Front-end controller for the shared-multiplier datapath. Accepts altitude (k1*x1+k2*x2)
//  and battery (v*t+c) requests on two valid/ready ports and arbitrates between them round-robin.
//  Holds operands and sel_eq stable to the datapath for a fixed window, then captures the result.
//  Returns the tagged result on a valid/ready output port. One transaction in flight at a time.
// PARAMETERS
//  LATENCY   4  cycles operands/sel_eq are held before the result is captured (must be >= 4)
//  CNT_W     8  width of per-equation completion counters (wrap-around)
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  rst            in   1      asynchronous, active-high reset
//  alt_valid      in   1      altitude request valid
//  alt_ready      out  1      altitude request accepted when alt_valid&&alt_ready
//  alt_x1         in   8      signed altitude operand x1
//  alt_x2         in   8      signed altitude operand x2
//  bat_valid      in   1      battery request valid
//  bat_ready      out  1      battery request accepted when bat_valid&&bat_ready
//  bat_v          in   8      signed battery operand v
//  bat_t          in   8      signed battery operand t
//  bat_c          in   8      signed battery operand c
//  dp_x1,dp_x2    out  8      operands to datapath (altitude)
//  dp_v,dp_t,dp_c out  8      operands to datapath (battery)
//  dp_sel_eq      out  1      0 = altitude, 1 = battery
//  dp_result_a    in   16     datapath altitude result
//  dp_result_b    in   16     datapath battery result
//  res_valid      out  1      result available
//  res_ready      in   1      consumer accepts result when res_valid&&res_ready
//  res_data       out  16     captured result (two's complement)
//  res_is_bat     out  1      tag: 0 altitude, 1 battery
//  alt_done_cnt   out  CNT_W  completed altitude transactions delivered
//  bat_done_cnt   out  CNT_W  completed battery transactions delivered
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr pointer favours altitude; counters 0.
//  FSM IDLE -> ISSUE -> HOLD -> IDLE.
//  IDLE: ready asserted combinationally only for the granted port, never both.
//   Grant is the single valid port; if both valid, grant the one not served last (altitude after reset).
//   On accept, latch operands and tag; load wait counter with LATENCY-1; go ISSUE. No valid: stay.
//  ISSUE: drive dp_* from latched regs; unused-equation operands driven 0; dp_sel_eq = tag.
//   Counter decrements each cycle. At 0: capture dp_result_a (tag 0) or dp_result_b (tag 1)
//   into res_data and set res_is_bat. Set res_valid, go HOLD. Operands stay frozen throughout ISSUE.
//   Requesters may change inputs after acceptance.
//  HOLD: res_valid=1, res_data/res_is_bat stable until handshake. On res_ready: res_valid->0.
//   Increment the matching done counter (wraps 2^CNT_W-1 -> 0), update rr pointer, go IDLE.
//  res_ready while res_valid=0 is ignored.
//  New requests are not accepted in the handshake cycle; the next accept is earliest 1 cycle later.
//   Throughput: 1 result per LATENCY+2 cycles with res_ready held high.
//  IDLE/HOLD: dp_* operands and dp_sel_eq driven 0.
//  rst mid-ISSUE or mid-HOLD: transaction dropped, no result, counters cleared.
//  A request valid that drops before ready is simply not served; no latching occurs.
//  All arithmetic lives in the datapath; this block only moves and tags 16-bit values.
// TESTING
//  1 Alt x1=10,x2=4 alone -> alt_ready 1 cycle, res_valid after LATENCY+1, res_data=0x0032, tag 0.
//  2 Bat v=6,t=7,c=5 -> res_data=0x002F, res_is_bat=1, bat_done_cnt=1 after handshake.
//  3 Both valid every cycle from reset -> grants alt,bat,alt,bat; counters equal after each pair.
//  4 Signed: x1=0xFE,x2=0x01 -> res_data=0xFFFF; v=0xFF,t=0x02,c=0x80 -> 0xFF7E.
//  5 res_ready low 10 cycles -> res_valid/res_data stable, no ready to requesters; then completes.
//  6 rst asserted mid-ISSUE -> outputs 0 next edge, IDLE. 256 alt txns -> alt_done_cnt wraps to 0.

Source files
------------

// File: rtl/eq_sequencer.sv
// Front-end sequencer for the shared-multiplier datapath: round-robin arbitration of altitude and
// battery requests, a fixed operand hold window, result capture and tagged valid/ready return.
module eq_sequencer #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alt_valid,
  output logic             alt_ready,
  input  logic [7:0]       alt_x1,
  input  logic [7:0]       alt_x2,
  input  logic             bat_valid,
  output logic             bat_ready,
  input  logic [7:0]       bat_v,
  input  logic [7:0]       bat_t,
  input  logic [7:0]       bat_c,
  output logic [7:0]       dp_x1,
  output logic [7:0]       dp_x2,
  output logic [7:0]       dp_v,
  output logic [7:0]       dp_t,
  output logic [7:0]       dp_c,
  output logic             dp_sel_eq,
  input  logic [15:0]      dp_result_a,
  input  logic [15:0]      dp_result_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_is_bat,
  output logic [CNT_W-1:0] alt_done_cnt,
  output logic [CNT_W-1:0] bat_done_cnt
);

  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              tag;
  logic              prefer_bat;
  logic [7:0]        x1_q;
  logic [7:0]        x2_q;
  logic [7:0]        v_q;
  logic [7:0]        t_q;
  logic [7:0]        c_q;
  logic              grant_alt;
  logic              grant_bat;
  logic              accept_alt;
  logic              accept_bat;
  logic              in_issue;
  logic              res_fire;

  // A lone requester always wins; on contention the pointer picks the side not served last.
  always_comb begin
    grant_alt = alt_valid && (!bat_valid || !prefer_bat);
    grant_bat = bat_valid && (!alt_valid || prefer_bat);
  end

  assign alt_ready  = (state == IDLE) && grant_alt;
  assign bat_ready  = (state == IDLE) && grant_bat;
  assign accept_alt = alt_valid && alt_ready;
  assign accept_bat = bat_valid && bat_ready;
  assign in_issue   = (state == ISSUE);
  assign res_fire   = (state == HOLD) && res_valid && res_ready;

  assign dp_x1     = (in_issue && !tag) ? x1_q : 8'd0;
  assign dp_x2     = (in_issue && !tag) ? x2_q : 8'd0;
  assign dp_v      = (in_issue &&  tag) ? v_q  : 8'd0;
  assign dp_t      = (in_issue &&  tag) ? t_q  : 8'd0;
  assign dp_c      = (in_issue &&  tag) ? c_q  : 8'd0;
  assign dp_sel_eq = in_issue && tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tag      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_alt || accept_bat) begin
            tag      <= accept_bat;
            wait_cnt <= WAIT_W'(LATENCY - 1);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (wait_cnt == '0) begin
            state <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands are captured only at acceptance so requesters are free to move on afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_q <= 8'd0;
      x2_q <= 8'd0;
      v_q  <= 8'd0;
      t_q  <= 8'd0;
      c_q  <= 8'd0;
    end else if (accept_alt) begin
      x1_q <= alt_x1;
      x2_q <= alt_x2;
    end else if (accept_bat) begin
      v_q <= bat_v;
      t_q <= bat_t;
      c_q <= bat_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_data   <= 16'd0;
      res_is_bat <= 1'b0;
    end else if (in_issue && (wait_cnt == '0)) begin
      res_valid  <= 1'b1;
      res_data   <= tag ? dp_result_b : dp_result_a;
      res_is_bat <= tag;
    end else if (res_fire) begin
      res_valid <= 1'b0;
    end
  end

  // Completion counters and the round-robin pointer advance only on a delivered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alt_done_cnt <= '0;
      bat_done_cnt <= '0;
      prefer_bat   <= 1'b0;
    end else if (res_fire) begin
      prefer_bat <= !res_is_bat;
      if (res_is_bat) begin
        bat_done_cnt <= bat_done_cnt + CNT_W'(1);
      end else begin
        alt_done_cnt <= alt_done_cnt + CNT_W'(1);
      end
    end
  end

endmodule
